// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 pipelined multiplexer.
// Holds size limits, the channel tag type and the rotate-priority search.
package mux_pkg;

    localparam int MUX_N_MAX  = 16;
    localparam int MUX_W_MAX  = 64;
    localparam int MUX_SW_MAX = $clog2(MUX_N_MAX);

    typedef logic [MUX_SW_MAX-1:0] chan_t;

    // First valid channel after ptr, wrapping at n; returns {found, idx}.
    function automatic logic [MUX_SW_MAX:0] rr_next(
        input logic [MUX_N_MAX-1:0] valid,
        input chan_t                ptr,
        input int                   n
    );
        logic [MUX_SW_MAX:0] r;
        chan_t               j;
        r = '0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int k = MUX_N_MAX; k >= 1; k--) begin
            j = chan_t'((int'(ptr) + k) % n);
            if (k <= n && valid[j]) begin
                r = {1'b1, j};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotate-priority picker for round-robin selection.
// Used only when MUX_RR_EN is defined; the pointer register lives in the top.
module mux_rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [MUX_N_MAX-1:0] v_ext;
    logic [MUX_SW_MAX:0]  r;

    // Search upward from ptr+1 for the next requesting channel.
    always_comb begin
        v_ext        = '0;
        v_ext[N-1:0] = valid;
        r            = rr_next(v_ext, chan_t'(ptr), N);
        found        = r[MUX_SW_MAX];
        idx          = SW'(r[MUX_SW_MAX-1:0]);
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 data mux with a single registered output slot and valid/ready handshakes.
// Optional round-robin selection is built when the MUX_RR_EN macro is defined.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    input  logic [SW-1:0] sel,
    input  logic          rr_mode,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_chan,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sel_err
);

    logic          can_load;
    logic          c_ok;
    logic          xfer_in;
    logic          err_d;
    logic [SW-1:0] c;
    logic [W-1:0]  c_data;

`ifdef MUX_RR_EN
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_idx;
    logic          rr_found;

    mux_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .valid (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );
`else
    logic unused_rr;
    assign unused_rr = rr_mode;
`endif

    // Effective channel: explicit sel, or the round-robin pick.
    always_comb begin
        c     = sel;
        c_ok  = ({1'b0, sel} < (SW+1)'(N));
        err_d = !c_ok && |in_valid;
`ifdef MUX_RR_EN
        if (rr_mode) begin
            c     = rr_idx;
            c_ok  = rr_found;
            err_d = 1'b0;
        end
`endif
    end

    assign can_load = !out_valid || out_ready;

    // Grant decode and data steering for the chosen channel.
    always_comb begin
        in_ready = '0;
        c_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == c) begin
                c_data = in_data[i*W +: W];
            end
            if (rst_n && can_load && c_ok) begin
                in_ready[i] = (SW'(i) == c);
            end
        end
    end

    assign xfer_in = |(in_ready & in_valid);

    // Output slot: a new word replaces the departing one on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= err_d;
            if (xfer_in) begin
                out_valid <= 1'b1;
                out_data  <= c_data;
                out_chan  <= c;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_RR_EN
    // Round-robin pointer follows the most recently granted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SW'(N-1);
        end else if (xfer_in) begin
            ptr <= c;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: directed vectors plus a cycle model.
// Round-robin vectors are exercised only when MUX_RR_EN is defined.
module tb_mux_nx1_pipe;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           rr_mode;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        sel_err3;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mux_nx1_pipe #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    mux_nx1_pipe #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .rr_mode   (1'b0),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .sel_err   (sel_err3)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one output slot plus the round-robin pointer.
    bit         m_valid = 0;
    logic [7:0] m_data  = '0;
    int         m_chan  = 0;
    bit         m_err   = 0;
    int         m_ptr   = N-1;

    function automatic int pick();
`ifdef MUX_RR_EN
        if (rr_mode) begin
            for (int k = 1; k <= N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
`endif
        if (int'(sel) < N) return int'(sel);
        return -1;
    endfunction

    always begin : model
        int         c;
        bit         can, xin;
        logic [N-1:0] er;
        bit         nv, ne;
        logic [7:0] nd;
        int         nc, np;
        @(negedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_err = 0; m_ptr = N-1;
        end
        check("m_out_valid", out_valid, m_valid);
        check("m_sel_err", sel_err, m_err);
        if (m_valid) begin
            check("m_out_data", out_data, m_data);
            check("m_out_chan", out_chan, m_chan);
        end
        c   = pick();
        can = !m_valid || out_ready;
        er  = '0;
        if (rst_n && can && c >= 0) er[c] = 1'b1;
        check("m_in_ready", in_ready, er);
        xin = (c >= 0) && er[c] && in_valid[c];
        nv = m_valid; nd = m_data; nc = m_chan; np = m_ptr;
        if (xin) begin
            nv = 1; nd = in_data[c*W +: W]; nc = c; np = c;
        end else if (out_ready) begin
            nv = 0;
        end
        ne = (int'(sel) >= N) && (in_valid != 0);
`ifdef MUX_RR_EN
        if (rr_mode) ne = 0;
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_err = 0; m_ptr = N-1;
        end else begin
            m_valid = nv; m_data = nd; m_chan = nc; m_err = ne; m_ptr = np;
        end
    end

    logic [7:0] exp_d[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef MUX_RR_EN
    int rr_a[6] = '{0, 1, 3, 0, 1, 3};
    int rr_b[3] = '{3, 0, 3};
`endif

    initial begin
        rst_n     = 1'b0;
        in_data   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        in_valid  = '0;
        sel       = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b0;
        in_data3  = {8'h33, 8'h22, 8'h11};
        in_valid3 = '0;
        sel3      = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_in_ready", in_ready, 0);
        step();
        step();
        rst_n = 1'b1;

        // Explicit select walks all four channels.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = SW'(k);
            step();
            check("seq_valid", out_valid, 1);
            check("seq_data", out_data, exp_d[k]);
            check("seq_chan", out_chan, k);
        end

        // Stall with B2 held, then release.
        sel = 2'd1;
        step();
        check("stall_load", out_data, 8'hB2);
        out_ready = 1'b0;
        sel       = 2'd2;
        #1;
        check("stall_rdy0", in_ready, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_data", out_data, 8'hB2);
            check("stall_rdy", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("release_rdy", in_ready, 4'b0100);
        step();
        check("release_data", out_data, 8'hC3);
        check("release_chan", out_chan, 2);
        in_valid = '0;
        step();
        check("drain_valid", out_valid, 0);

        // Asynchronous reset in the middle of traffic.
        in_valid = 4'b1111;
        sel      = 2'd0;
        step();
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_data", out_data, 0);
        check("async_chan", out_chan, 0);
        check("async_rdy", in_ready, 0);
        step();
        rst_n    = 1'b1;
        in_valid = '0;

        // Out-of-range select on a 3-channel instance.
        sel3      = 2'd3;
        in_valid3 = 3'b001;
        #1;
        check("n3_rdy", in_ready3, 3'b000);
        step();
        check("n3_err", sel_err3, 1);
        check("n3_valid", out_valid3, 0);
        in_valid3 = 3'b000;
        step();
        check("n3_err_clr", sel_err3, 0);
        check("n3_valid2", out_valid3, 0);
        sel3      = 2'd2;
        in_valid3 = 3'b100;
        step();
        check("n3_data", out_data3, 8'h33);
        check("n3_chan", out_chan3, 2);
        in_valid3 = 3'b000;

`ifdef MUX_RR_EN
        // Round-robin rotation over channels 0, 1 and 3.
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        rr_mode   = 1'b1;
        sel       = 2'd2;
        out_ready = 1'b1;
        in_valid  = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_chan", out_chan, rr_a[k]);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rr2_c0", out_chan, 0);
        step();
        check("rr2_c1", out_chan, 1);
        in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rr2_chan", out_chan, rr_b[k]);
        end
        rr_mode = 1'b0;
`endif

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_EN
            rr_mode   = 1'($urandom_range(0, 1));
`endif
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
